// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: Diff = X - Y computed LSB first, one bit per clock,
// using a single full-subtractor cell with a registered borrow.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] xs, ys, rs, rs_nxt;
    logic [CW-1:0]    cnt;
    logic             b, b_nxt, d;
    logic             last, accept;

    // Handshake: start is a request sampled on every rising edge; it is taken
    // (operands captured) only when not busy, i.e. in IDLE or DONE, and is
    // silently dropped during RUN. done pulses for one cycle; Diff/Bout stay
    // valid from that cycle until the next completion overwrites them.
    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(WIDTH - 1));

    assign d      = xs[0] ^ ys[0] ^ b;
    assign b_nxt  = (~xs[0] & ys[0]) | (~(xs[0] ^ ys[0]) & b);
    assign rs_nxt = {d, rs[WIDTH-1:1]};

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs   <= '0;
            ys   <= '0;
            rs   <= '0;
            b    <= 1'b0;
            cnt  <= '0;
            Diff <= '0;
            Bout <= 1'b0;
        end else if (accept) begin
            xs  <= X;
            ys  <= Y;
            rs  <= '0;
            b   <= 1'b0;
            cnt <= '0;
        end else if (state == RUN) begin
            xs  <= xs >> 1;
            ys  <= ys >> 1;
            rs  <= rs_nxt;
            b   <= b_nxt;
            cnt <= cnt + 1'b1;
            // Results are published only on completion so they never show partial bits.
            if (last) begin
                Diff <= rs_nxt;
                Bout <= b_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=8): latency, corner operands,
// ignored start in RUN, back-to-back start in DONE, async reset mid-run, hold.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         busy, done, Bout;
    logic [W-1:0] Diff;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0] exp_q[$];

    serial_sub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
        .busy(busy), .done(done), .Diff(Diff), .Bout(Bout), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Checks busy for W cycles then the done cycle against the head of exp_q.
    task automatic finish_op(input string tag);
        logic [W:0] e;
        for (int i = 0; i < W; i++) begin
            check({tag, " busy"}, {32'd0, busy}, 33'd1);
            check({tag, " no_done"}, {32'd0, done}, 33'd0);
            @(negedge clk);
        end
        check({tag, " done"}, {32'd0, done}, 33'd1);
        check({tag, " busy_low"}, {32'd0, busy}, 33'd0);
        if (exp_q.size() == 0) begin
            check({tag, " exp_q_empty"}, 33'd1, 33'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " result"}, {24'd0, Bout, Diff}, {24'd0, e});
        end
    endtask

    // Called at a negedge; returns at the negedge after the done cycle.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] ed, input logic eb);
        X = x; Y = y; start = 1'b1;
        exp_q.push_back({eb, ed});
        @(negedge clk);
        start = 1'b0;
        X = W'($urandom_range(0, 255));
        Y = W'($urandom_range(0, 255));
        finish_op(tag);
        @(negedge clk);
        check({tag, " done_pulse"}, {32'd0, done}, 33'd0);
    endtask

    initial begin
        logic [W-1:0] rx, ry;
        logic [W:0]   rf;

        repeat (2) @(negedge clk);
        check("reset state", {31'd0, dbg_state}, 33'd0);
        check("reset outs", {22'd0, busy, done, Bout, Diff}, 33'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("5-3", 8'd5, 8'd3, 8'h02, 1'b0);
        for (int i = 0; i < 20; i++) begin
            X = W'($urandom_range(0, 255));
            Y = W'($urandom_range(0, 255));
            @(negedge clk);
            check("hold", {23'd0, done, Bout, Diff}, {23'd0, 1'b0, 1'b0, 8'h02});
        end

        run_op("3-5",    8'd3,   8'd5,   8'hFE, 1'b1);
        run_op("0-0",    8'd0,   8'd0,   8'h00, 1'b0);
        run_op("FF-FF",  8'hFF,  8'hFF,  8'h00, 1'b0);
        run_op("0-1",    8'd0,   8'd1,   8'hFF, 1'b1);
        run_op("80-01",  8'h80,  8'h01,  8'h7F, 1'b0);
        run_op("AA-55",  8'hAA,  8'h55,  8'h55, 1'b0);

        // start held through RUN: ignored, then relaunches in DONE with no bubble
        X = 8'd10; Y = 8'd4; start = 1'b1;
        exp_q.push_back({1'b0, 8'd6});
        exp_q.push_back({1'b1, 8'hFF});
        @(negedge clk);
        X = 8'd1; Y = 8'd2;
        finish_op("held");
        @(negedge clk);
        start = 1'b0;
        finish_op("b2b");
        @(negedge clk);

        // async reset mid-run discards the in-flight operation
        X = 8'd200; Y = 8'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-reset busy", {32'd0, busy}, 33'd1);
        rst_n = 1'b0;
        #1;
        check("async reset", {22'd0, busy, done, Bout, Diff}, 33'd0);
        check("async reset state", {31'd0, dbg_state}, 33'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("9-9", 8'd9, 8'd9, 8'h00, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rx = W'($urandom_range(0, 255));
            ry = W'($urandom_range(0, 255));
            rf = {1'b0, rx} - {1'b0, ry};
            run_op("random", rx, ry, rf[W-1:0], rf[W]);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        check("exp_q drained", 33'(exp_q.size()), 33'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
